// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and
// D-cache miss handlers. D requests win over I requests. Fills issue one
// address per cycle for a whole block and hand returning words to the owner.
// D-cache stores go out as single-cycle write-throughs.
// Optional build macro MEM_ARB_PERF_CNT_EN adds four 16-bit saturating
// counters: completed I fills, completed D fills, D writes, and IDLE cycles
// in which both caches were requesting.
module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              i_done,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [2:0]        dbg_state
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]       i_fill_cnt,
    output logic [15:0]       d_fill_cnt,
    output logic [15:0]       d_write_cnt,
    output logic [15:0]       contention_cnt
`endif
);

    // Handshake: a cache raises *_req and holds it (with its address/data
    // stable) until *_done pulses; *_grant is high for the whole operation
    // and dropping *_req mid-operation does not abort it.

    typedef enum logic [2:0] {
        DRAIN   = 3'd0,
        IDLE    = 3'd1,
        I_FILL  = 3'd2,
        D_FILL  = 3'd3,
        D_WRITE = 3'd4
    } state_t;

    localparam int                DRAIN_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int                BLK_BITS = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLK_BITS) - 1);

    state_t              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [IDX_W:0]      issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]    recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;

    assign dbg_state = state_q;

    // State and counter registers; reset lands in DRAIN with everything cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    // Next-state, counters and all port outputs, decoded from the current state.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        base_d       = base_q;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_data    = '0;
        fill_idx     = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            DRAIN: begin
                // Let any read issued before reset come back and be dropped.
                if (drain_cnt_q == DRAIN_W'(MEM_LAT - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                if (d_req) begin
                    base_d  = d_addr & BLK_MASK;
                    state_d = d_we ? D_WRITE : D_FILL;
                end else if (i_req) begin
                    base_d  = i_addr & BLK_MASK;
                    state_d = I_FILL;
                end
            end
            I_FILL, D_FILL: begin
                i_grant  = (state_q == I_FILL);
                d_grant  = (state_q == D_FILL);
                fill_idx = recv_cnt_q;
                if (issue_cnt_q < (IDX_W + 1)'(WORDS_PER_BLOCK)) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q | ADDR_W'({issue_cnt_q[IDX_W-1:0], 1'b0});
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_data_valid) begin
                    i_fill_valid = i_grant;
                    d_fill_valid = d_grant;
                    fill_data    = mem_rdata;
                    recv_cnt_d   = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        i_done  = i_grant;
                        d_done  = d_grant;
                        state_d = IDLE;
                    end
                end
            end
            D_WRITE: begin
                d_grant   = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] i_fill_cnt_q, i_fill_cnt_d;
    logic [15:0] d_fill_cnt_q, d_fill_cnt_d;
    logic [15:0] d_write_cnt_q, d_write_cnt_d;
    logic [15:0] contention_cnt_q, contention_cnt_d;

    assign i_fill_cnt     = i_fill_cnt_q;
    assign d_fill_cnt     = d_fill_cnt_q;
    assign d_write_cnt    = d_write_cnt_q;
    assign contention_cnt = contention_cnt_q;

    // Saturating event counts; each holds once it reaches all-ones.
    always_comb begin
        i_fill_cnt_d     = i_fill_cnt_q;
        d_fill_cnt_d     = d_fill_cnt_q;
        d_write_cnt_d    = d_write_cnt_q;
        contention_cnt_d = contention_cnt_q;
        if (i_done && i_fill_cnt_q != 16'hFFFF)
            i_fill_cnt_d = i_fill_cnt_q + 16'd1;
        if (d_done && state_q == D_FILL && d_fill_cnt_q != 16'hFFFF)
            d_fill_cnt_d = d_fill_cnt_q + 16'd1;
        if (d_done && state_q == D_WRITE && d_write_cnt_q != 16'hFFFF)
            d_write_cnt_d = d_write_cnt_q + 16'd1;
        if (state_q == IDLE && i_req && d_req && contention_cnt_q != 16'hFFFF)
            contention_cnt_d = contention_cnt_q + 16'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_fill_cnt_q     <= '0;
            d_fill_cnt_q     <= '0;
            d_write_cnt_q    <= '0;
            contention_cnt_q <= '0;
        end else begin
            i_fill_cnt_q     <= i_fill_cnt_d;
            d_fill_cnt_q     <= d_fill_cnt_d;
            d_write_cnt_q    <= d_write_cnt_d;
            contention_cnt_q <= contention_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 4-cycle pipelined memory model returning ~addr.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam logic [2:0] S_DRAIN = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_grant, d_grant, i_fill_valid, d_fill_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_done, d_done, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic [2:0]  dbg_state;
    logic        stray_valid;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] i_fill_cnt, d_fill_cnt, d_write_cnt, contention_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_i_fills = 0;
    int exp_d_fills = 0;
    int exp_d_writes = 0;
    int exp_contention = 0;

    logic [15:0] exp_q[$];
    logic [15:0] addr_q[$];
    logic [31:0] wr_q[$];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .i_done(i_done), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .dbg_state(dbg_state)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .i_fill_cnt(i_fill_cnt), .d_fill_cnt(d_fill_cnt),
        .d_write_cnt(d_write_cnt), .contention_cnt(contention_cnt)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pipelined memory: read issued in cycle k returns in cycle k+MEM_LAT
    logic        pipe_v [MEM_LAT] = '{default: 1'b0};
    logic [15:0] pipe_d [MEM_LAT] = '{default: 16'h0};
    always @(posedge clk) begin
        pipe_v[0] <= mem_en && !mem_wr;
        pipe_d[0] <= ~mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_data_valid = pipe_v[MEM_LAT-1] | stray_valid;
    assign mem_rdata      = stray_valid ? 16'h5555 : pipe_d[MEM_LAT-1];

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full-block fill for one cache; caller is at a negedge with DUT in IDLE.
    task automatic do_fill(input bit is_d, input logic [15:0] addr, input bit drop_req);
        logic [15:0] base, exp_a, exp_d;
        int cyc, words, dones;
        logic own_grant, oth_grant, own_valid, oth_valid, own_done;
        base = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(base + 16'(2 * i));
            exp_q.push_back(~(base + 16'(2 * i)));
        end
        if (is_d) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = addr; exp_d_fills++;
        end else begin
            i_req = 1'b1; i_addr = addr; exp_i_fills++;
        end
        @(negedge clk);
        cyc = 0; words = 0; dones = 0;
        while (dones == 0 && cyc < 40) begin
            own_grant = is_d ? d_grant : i_grant;
            oth_grant = is_d ? i_grant : d_grant;
            own_valid = is_d ? d_fill_valid : i_fill_valid;
            oth_valid = is_d ? i_fill_valid : d_fill_valid;
            own_done  = is_d ? d_done : i_done;
            checks++;
            if (own_grant !== 1'b1 || oth_grant !== 1'b0) begin
                errors++;
                $display("FAIL fill_grant cyc=%0d own=%b other=%b required own=1 other=0", cyc, own_grant, oth_grant);
            end
            if (mem_en === 1'b1) begin
                checks++;
                if (addr_q.size() == 0 || cyc > 7 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_issue cyc=%0d addr=%h wr=%b required no access", cyc, mem_addr, mem_wr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (mem_addr !== exp_a) begin
                        errors++;
                        $display("FAIL fill_addr cyc=%0d got=%h required=%h", cyc, mem_addr, exp_a);
                    end
                end
            end
            checks++;
            if (oth_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_other_valid cyc=%0d got=%b required=0", cyc, oth_valid);
            end
            if (own_valid === 1'b1) begin
                checks++;
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                if (fill_data !== exp_d || fill_idx !== 3'(words)) begin
                    errors++;
                    $display("FAIL fill_word cyc=%0d data=%h idx=%0d required data=%h idx=%0d",
                             cyc, fill_data, fill_idx, exp_d, words);
                end
                words++;
            end
            if (own_done === 1'b1) begin
                dones++;
                checks++;
                if (cyc != 7 + MEM_LAT || words != 8) begin
                    errors++;
                    $display("FAIL fill_done cyc=%0d words=%0d required cyc=%0d words=8", cyc, words, 7 + MEM_LAT);
                end
            end
            if (drop_req && cyc == 0) begin
                if (is_d) d_req = 1'b0; else i_req = 1'b0;
            end
            if (dones == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        checks++;
        if (dones == 0 || addr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fill_complete dones=%0d addr_left=%0d words_left=%0d required 1 0 0",
                     dones, addr_q.size(), exp_q.size());
        end
        addr_q.delete();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (i_grant !== 1'b0 || d_grant !== 1'b0 || mem_en !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL fill_after ig=%b dg=%b en=%b idone=%b ddone=%b required all 0",
                     i_grant, d_grant, mem_en, i_done, d_done);
        end
    endtask

    // Single-word store; caller is at a negedge with DUT in IDLE.
    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        logic [31:0] e;
        wr_q.push_back({addr, data});
        exp_d_writes++;
        d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data;
        @(negedge clk);
        e = wr_q.pop_front();
        checks++;
        if (d_grant !== 1'b1 || i_grant !== 1'b0 || mem_en !== 1'b1 || mem_wr !== 1'b1 ||
            mem_addr !== e[31:16] || mem_wdata !== e[15:0] || d_done !== 1'b1) begin
            errors++;
            $display("FAIL write_cycle dg=%b ig=%b en=%b wr=%b addr=%h wdata=%h done=%b required 1 0 1 1 %h %h 1",
                     d_grant, i_grant, mem_en, mem_wr, mem_addr, mem_wdata, d_done, e[31:16], e[15:0]);
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || d_grant !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL write_after en=%b dg=%b done=%b required 0 0 0", mem_en, d_grant, d_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; stray_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== S_DRAIN || i_grant !== 1'b0 || d_grant !== 1'b0 || mem_en !== 1'b0 ||
            mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || fill_data !== 16'h0 ||
            fill_idx !== 3'd0 || i_done !== 1'b0 || d_done !== 1'b0 || i_fill_valid !== 1'b0 || d_fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d en=%b addr=%h ig=%b dg=%b required all 0", dbg_state, mem_en, mem_addr, i_grant, d_grant);
        end
        rst_n = 1'b1;
        for (int i = 0; i < MEM_LAT; i++) begin
            #1;
            checks++;
            if (dbg_state !== S_DRAIN || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_drain i=%0d state=%0d en=%b required %0d 0", i, dbg_state, mem_en, S_DRAIN);
            end
            @(negedge clk);
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_idle state=%0d required %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_i_fill();
        do_fill(1'b0, 16'h1234, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        i_req = 1'b1; i_addr = 16'h4560;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 16'h4560 + 16'(2 * k)) begin
                errors++;
                $display("FAIL rst_mid_addr k=%0d en=%b addr=%h required 1 %h", k, mem_en, mem_addr, 16'h4560 + 16'(2 * k));
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_DRAIN || i_grant !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 16'h0 ||
            i_fill_valid !== 1'b0 || fill_data !== 16'h0 || i_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_zero state=%0d ig=%b en=%b addr=%h required %0d 0 0 0", dbg_state, i_grant, mem_en, mem_addr, S_DRAIN);
        end
        rst_n = 1'b1;
        exp_i_fills = 0; exp_d_fills = 0; exp_d_writes = 0; exp_contention = 0;
        for (int i = 0; i < MEM_LAT; i++) begin
            stray_valid = (i == 1);
            #1;
            checks++;
            if (dbg_state !== S_DRAIN || i_grant !== 1'b0 || mem_en !== 1'b0 || i_fill_valid !== 1'b0 || fill_data !== 16'h0) begin
                errors++;
                $display("FAIL rst_mid_drain i=%0d state=%0d ig=%b en=%b iv=%b data=%h required %0d 0 0 0 0",
                         i, dbg_state, i_grant, mem_en, i_fill_valid, fill_data, S_DRAIN);
            end
            @(negedge clk);
            stray_valid = 1'b0;
        end
        checks++;
        if (dbg_state !== S_IDLE || i_grant !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle state=%0d ig=%b required %0d 0", dbg_state, i_grant, S_IDLE);
        end
        do_fill(1'b0, 16'h4560, 1'b0);
    endtask

    task automatic test_d_write();
        do_write(16'h0040, 16'hBEEF);
        do_write(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
    endtask

    task automatic test_contention();
        i_req = 1'b1; i_addr = 16'h2468;
        exp_contention++;
        do_fill(1'b1, 16'h2000, 1'b0);
        do_fill(1'b0, 16'h2468, 1'b0);
    endtask

    task automatic test_dropped_req();
        do_fill(1'b1, 16'h3456, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 5; n++) begin
            case ($urandom_range(0, 2))
                0: do_fill(1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'b0);
                1: do_fill(1'b1, 16'($urandom_range(0, 16'hFFFF)), 1'b0);
                default: do_write(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
            endcase
        end
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf_counters();
        checks++;
        if (i_fill_cnt !== 16'(exp_i_fills) || d_fill_cnt !== 16'(exp_d_fills) ||
            d_write_cnt !== 16'(exp_d_writes) || contention_cnt !== 16'(exp_contention)) begin
            errors++;
            $display("FAIL perf_counts got %0d %0d %0d %0d required %0d %0d %0d %0d",
                     i_fill_cnt, d_fill_cnt, d_write_cnt, contention_cnt,
                     exp_i_fills, exp_d_fills, exp_d_writes, exp_contention);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_i_fill();
        test_reset_mid_fill();
        test_d_write();
        test_contention();
        test_dropped_req();
        test_back_to_back();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
